// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline sequencing controller for a 3-stage RV32I core. It decodes the
//   immediate format of the decode-stage instruction and is the single owner
//   of fetch stall, ID/EX bubble and PC redirect.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to add two performance counters.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   if_valid        if_instr holds a valid instruction
//   if_instr[31:0]  instruction in decode
//   ex_br_taken     execute resolved a taken branch / JAL / JALR
//   ex_is_load      execute holds a load
//   ex_rd[4:0]      destination register of the execute-stage instruction
//   dmem_ready      data memory returned load data this cycle
//   pc_stall        hold PC and IF/ID
//   id_ex_flush     insert a bubble into ID/EX
//   pc_sel          select the branch target as next PC
//   imm_sel[2:0]    0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   load_err        sticky load-timeout flag
//   state[1:0]      0 RUN, 1 LOAD_WAIT, 2 FLUSH
//   perf_stall_cnt  (HAZARD_PERF_CNT_EN) cycles with pc_stall=1
//   perf_flush_cnt  (HAZARD_PERF_CNT_EN) cycles with id_ex_flush=1 and pc_stall=0
module hazard_sequencer #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int MAX_LOAD_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic        ex_br_taken,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        id_ex_flush,
  output logic        pc_sel,
  output logic [2:0]  imm_sel,
  output logic        load_err,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {RUN = 2'd0, LOAD_WAIT = 2'd1, FLUSH = 2'd2} st_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(MAX_LOAD_WAIT);

  st_e        cur;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic       use_rs1, use_rs2, load_use;
  logic [6:0] opc;
  logic [4:0] rs1, rs2;

  assign opc   = if_instr[6:0];
  assign rs1   = if_instr[19:15];
  assign rs2   = if_instr[24:20];
  assign state = cur;

  // funct/rd fields are not needed for hazard detection
  logic unused_instr_bits;
  assign unused_instr_bits = ^{if_instr[31:25], if_instr[14:7]};

  // Immediate format and register-source usage from the opcode
  always_comb begin
    imm_sel = 3'd0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      7'b0000011, 7'b0010011, 7'b1100111: begin imm_sel = 3'd1; use_rs1 = 1'b1; end
      7'b0100011: begin imm_sel = 3'd2; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100011: begin imm_sel = 3'd3; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0110111, 7'b0010111: imm_sel = 3'd4;
      7'b1101111: imm_sel = 3'd5;
      7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default: ;
    endcase
    if (!if_valid) imm_sel = 3'd0;
  end

  assign load_use = if_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));

  // Control outputs are combinational so a redirect or stall takes effect in
  // the same cycle the condition appears. Held low while reset is asserted.
  always_comb begin
    pc_stall    = 1'b0;
    id_ex_flush = 1'b0;
    pc_sel      = 1'b0;
    if (!rst) begin
      case (cur)
        RUN: begin
          if (ex_br_taken) begin
            pc_sel      = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_is_load & !dmem_ready) begin
            pc_stall    = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        LOAD_WAIT: begin
          pc_stall    = !dmem_ready;
          id_ex_flush = !dmem_ready;
        end
        FLUSH: id_ex_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= RUN;
      flush_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      load_err  <= 1'b0;
    end else begin
      case (cur)
        RUN: begin
          if (ex_br_taken) begin
            // The redirect cycle is itself the first bubble
            if (FLUSH_CYCLES > 1) begin
              cur       <= FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end else if (ex_is_load & !dmem_ready) begin
            cur      <= LOAD_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        LOAD_WAIT: begin
          if (dmem_ready) begin
            cur      <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_MAX) begin
            load_err <= 1'b1;
            cur      <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1) cur <= RUN;
        end
        default: cur <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_ex_flush & !pc_stall) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
  localparam int FC  = 2;
  localparam int MLW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic        ex_br_taken = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        dmem_ready = 1'b1;
  logic        pc_stall, id_ex_flush, pc_sel, load_err;
  logic [2:0]  imm_sel;
  logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_sequencer #(.FLUSH_CYCLES(FC), .MAX_LOAD_WAIT(MLW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .ex_br_taken(ex_br_taken), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .dmem_ready(dmem_ready), .pc_stall(pc_stall), .id_ex_flush(id_ex_flush),
    .pc_sel(pc_sel), .imm_sel(imm_sel), .load_err(load_err),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .state(state)
  );

  typedef struct {
    logic        stall, flush, sel, err;
    logic [2:0]  imm;
    logic [1:0]  st;
    logic [31:0] ps, pf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 running, 1 waiting on memory, 2 draining bubbles
  int          m_mode = 0;
  int          m_left = 0;
  int          m_waited = 0;
  bit          m_err = 1'b0;
  int unsigned m_ps = 0, m_pf = 0;

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_imm(logic [31:0] ins);
    logic [6:0] o;
    o = ins[6:0];
    if (o inside {7'h03, 7'h13, 7'h67}) return 3'd1;
    if (o == 7'h23) return 3'd2;
    if (o == 7'h63) return 3'd3;
    if (o inside {7'h37, 7'h17}) return 3'd4;
    if (o == 7'h6F) return 3'd5;
    return 3'd0;
  endfunction

  function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
    logic [6:0] o;
    o = ins[6:0];
    return ((o inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33}) && ins[19:15] == r) ||
           ((o inside {7'h23, 7'h63, 7'h33}) && ins[24:20] == r);
  endfunction

  // Apply one cycle of stimulus and queue the response the spec requires
  task automatic drive(bit r, bit v, logic [31:0] ins, bit br, bit ld,
                       logic [4:0] rd, bit rdy);
    exp_t e;
    @(posedge clk); #1;
    rst = r; if_valid = v; if_instr = ins; ex_br_taken = br;
    ex_is_load = ld; ex_rd = rd; dmem_ready = rdy;
    e = '{default: '0};
    e.imm = v ? ref_imm(ins) : 3'd0;
    if (r) begin
      m_mode = 0; m_left = 0; m_waited = 0; m_err = 1'b0; m_ps = 0; m_pf = 0;
      q.push_back(e);
      return;
    end
    e.st = 2'(m_mode); e.err = m_err; e.ps = m_ps; e.pf = m_pf;
    if (m_mode == 0) begin
      if (br) begin
        e.sel = 1'b1; e.flush = 1'b1;
        if (FC > 1) begin m_mode = 2; m_left = FC - 1; end
      end else if (ld && !rdy) begin
        e.stall = 1'b1; e.flush = 1'b1; m_mode = 1; m_waited = 1;
      end else if (v && ld && rd != 0 && reads_reg(ins, rd)) begin
        e.stall = 1'b1; e.flush = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (rdy) m_mode = 0;
      else begin
        e.stall = 1'b1; e.flush = 1'b1;
        if (m_waited == MLW) begin m_err = 1'b1; m_mode = 0; end
        else if (m_waited < 255) m_waited++;
      end
    end else begin
      e.flush = 1'b1;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    if (e.stall) m_ps++;
    if (e.flush && !e.stall) m_pf++;
    q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 0, 0, 5'd0, 1);
  endtask

  // Monitor: pops the expectation for every presented cycle and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pc_stall", pc_stall, e.stall);
        chk("sb_id_ex_flush", id_ex_flush, e.flush);
        chk("sb_pc_sel", pc_sel, e.sel);
        chk("sb_imm_sel", imm_sel, e.imm);
        chk("sb_load_err", load_err, e.err);
        chk("sb_state", state, e.st);
`ifdef HAZARD_PERF_CNT_EN
        chk("sb_perf_stall", perf_stall_cnt, e.ps);
        chk("sb_perf_flush", perf_flush_cnt, e.pf);
`endif
      end
    end
  end

  logic [31:0] sweep_ins [6] = '{32'h00A00093, 32'h00112023, 32'h00208463,
                                 32'h123450B7, 32'h008000EF, 32'h00000033};
  logic [2:0]  sweep_exp [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    int stalls;
    int unsigned p;
    logic [31:0] ins;
    int wait_cyc;

    // Reset state
    drive(1, 0, 32'd0, 0, 0, 5'd0, 1);
    @(negedge clk);
    chk("rst_state", state, 2'd0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_ctrl", {pc_stall, id_ex_flush, pc_sel}, 3'b000);

    // Opcode sweep
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, sweep_ins[i], 0, 0, 5'd0, 1);
      @(negedge clk);
      chk("sweep_imm", imm_sel, sweep_exp[i]);
    end
    drive(0, 0, 32'h00A00093, 0, 0, 5'd0, 1);
    @(negedge clk);
    chk("sweep_invalid", imm_sel, 3'd0);

    // Load-use on add x6,x5,x5
    drive(0, 1, 32'h00528333, 0, 1, 5'd5, 1);
    @(negedge clk);
    chk("lu_stall", {pc_stall, id_ex_flush}, 2'b11);
    idle();
    @(negedge clk);
    chk("lu_one_cycle", {pc_stall, id_ex_flush}, 2'b00);
    drive(0, 1, 32'h00528333, 0, 1, 5'd0, 1);
    @(negedge clk);
    chk("lu_x0", {pc_stall, id_ex_flush}, 2'b00);

    // Taken branch, two bubbles
    drive(0, 0, 32'd0, 1, 0, 5'd0, 1);
    @(negedge clk);
    chk("br_sel_flush", {pc_sel, id_ex_flush, state}, {2'b11, 2'd0});
    idle();
    @(negedge clk);
    chk("br_flush2", {pc_sel, pc_stall, id_ex_flush, state}, {3'b001, 2'd2});
    idle();
    @(negedge clk);
    chk("br_back_run", {id_ex_flush, state}, {1'b0, 2'd0});

    // Multi-cycle load, ready low 3 cycles after entry
    drive(1, 0, 32'd0, 0, 0, 5'd0, 1);
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'd0, 0, 1, 5'd3, i == 4);
      @(negedge clk);
      stalls += int'(pc_stall);
      if (i > 0) chk("ml_state", state, 2'd1);
    end
    idle();
    @(negedge clk);
    chk("ml_stall_cycles", stalls, 4);
    chk("ml_back_run", {state, load_err}, {2'd0, 1'b0});
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_4", perf_stall_cnt, 32'd4);
    chk("perf_flush_0", perf_flush_cnt, 32'd0);
`endif

    // Timeout: entry plus MLW waiting cycles, then sticky error
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'd0, 0, 1, 5'd3, 0);
      @(negedge clk);
    end
    chk("to_not_yet", load_err, 1'b0);
    drive(0, 0, 32'd0, 0, 1, 5'd3, 0);
    @(negedge clk);
    chk("to_err_set", {load_err, state}, {1'b1, 2'd0});
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'd0, 0, 1, 5'd3, 0);
      @(negedge clk);
    end
    chk("to_err_sticky", {load_err, state}, {1'b1, 2'd1});
    drive(1, 0, 32'd0, 0, 0, 5'd0, 1);
    @(negedge clk);
    chk("to_rst_mid", {state, pc_stall, id_ex_flush, pc_sel, load_err}, 6'd0);
    idle();

    // Randomized traffic, alternating between fast and slow memory phases
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 99);
      if (p == 0) drive(1, 0, 32'd0, 0, 0, 5'd0, 1);
      else begin
        ins = $urandom();
        ins[6:0]   = ops[$urandom_range(0, 10)];
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        drive(0, $urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
              (i % 512 < 256) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0));
      end
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    if (q.size() > 0) chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline sequencing controller for the 3-stage RV32I core. It decodes the immediate format of the instruction in decode and drives the immediate-format select. It also sequences fetch stalls, decode/execute bubbles and PC redirects for taken branches and jumps, multi-cycle data-memory loads and load-use hazards. Sits beside the decode stage and is the single owner of stall, flush and redirect.

Parameters:
FLUSH_CYCLES, 1, bubbles inserted after a redirect (1..7)
MAX_LOAD_WAIT, 15, cycles allowed in LOAD_WAIT before timeout (1..255)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
if_valid  in  1  if_instr holds a valid instruction
if_instr  in  32  instruction in the decode stage
ex_br_taken  in  1  execute stage resolved a taken branch, JAL or JALR
ex_is_load  in  1  execute stage holds a load
ex_rd  in  5  destination register of the execute-stage instruction
dmem_ready  in  1  data memory has returned load data this cycle
pc_stall  out  1  hold PC and the IF/ID register
id_ex_flush  out  1  insert a bubble into the ID/EX register
pc_sel  out  1  select the branch target as next PC
imm_sel  out  3  immediate format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
load_err  out  1  sticky load-timeout flag
state  out  2  0 RUN, 1 LOAD_WAIT, 2 FLUSH

Behaviour:
- Reset (async, immediate): state=RUN, flush_cnt=0, wait_cnt=0, load_err=0. pc_stall, id_ex_flush and pc_sel evaluate to 0.
- imm_sel is combinational from if_instr[6:0]. It is forced to 0 when if_valid=0.
  - 0000011, 0010011, 1100111 -> 1 (I)
  - 0100011 -> 2 (S)
  - 1100011 -> 3 (B)
  - 0110111, 0010111 -> 4 (U)
  - 1101111 -> 5 (J)
  - anything else -> 0
- Source usage:
  - rs1 = if_instr[19:15], used for opcodes 0000011, 0010011, 1100111, 0100011, 1100011, 0110011.
  - rs2 = if_instr[24:20], used for 0100011, 1100011, 0110011.
- load_use = if_valid & ex_is_load & ex_rd!=0 & (ex_rd matches a used source).
- RUN, evaluated in priority order:
  1. ex_br_taken: pc_sel=1 (combinational, same cycle) and id_ex_flush=1. Next state is FLUSH with flush_cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state stays RUN.
  2. Else ex_is_load & !dmem_ready: pc_stall=1 and id_ex_flush=1. Next state is LOAD_WAIT with wait_cnt=1.
  3. Else load_use: pc_stall=1 and id_ex_flush=1 for exactly this cycle. State stays RUN.
  4. Else all outputs are 0.
- LOAD_WAIT: pc_stall=!dmem_ready and id_ex_flush=!dmem_ready.
  - dmem_ready=1 -> RUN next cycle with wait_cnt=0.
  - wait_cnt==MAX_LOAD_WAIT & !dmem_ready -> load_err<=1 and RUN next cycle. load_err stays set until reset.
  - Otherwise wait_cnt increments (8-bit, saturating).
  - ex_br_taken is ignored in this state.
- FLUSH: id_ex_flush=1, pc_stall=0, pc_sel=0. flush_cnt decrements; at 0 the next state is RUN. ex_br_taken is ignored because execute holds bubbles.
- Simultaneous events: a taken branch beats a load wait, which beats load-use.
- Reset asserted mid-sequence returns to RUN immediately, with no residual stall or flush.
- Latency: pc_sel, pc_stall and id_ex_flush are combinational from inputs and state. State updates on the rising clk edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds output perf_stall_cnt (32) and output perf_flush_cnt (32).
  - perf_stall_cnt increments each cycle pc_stall=1.
  - perf_flush_cnt increments each cycle id_ex_flush=1 & pc_stall=0.
  - Both wrap at 2^32, and are cleared by rst.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Opcode sweep: if_valid=1 with if_instr=0x00A00093 (addi), 0x00112023 (sw), 0x00208463 (beq), 0x123450B7 (lui), 0x008000EF (jal), 0x00000033 (add) -> imm_sel 1, 2, 3, 4, 5, 0. With if_valid=0 -> imm_sel 0.
- Load-use: ex_is_load=1, ex_rd=5, dmem_ready=1, if_instr=0x00528333 (add x6,x5,x5) -> pc_stall=1 and id_ex_flush=1 for 1 cycle. With ex_rd=0 -> no stall.
- Taken branch with FLUSH_CYCLES=2: ex_br_taken pulse -> pc_sel=1 in that cycle, id_ex_flush=1 for 2 cycles, state RUN -> FLUSH -> RUN.
- Multi-cycle load: dmem_ready low for 3 cycles after entry -> pc_stall=1 for 4 cycles total, state=1, back to RUN, load_err=0.
- Timeout plus reset: dmem_ready held low with MAX_LOAD_WAIT=4 -> load_err=1 after the 5th stall cycle and stays set. Asserting rst mid-LOAD_WAIT -> state=0, all outputs 0, load_err=0.
- HAZARD_PERF_CNT_EN defined, rerun the multi-cycle-load scenario -> perf_stall_cnt=4, perf_flush_cnt=0.
